// File: rtl/timestamp_inject_pipe.sv
// ---------------------------------------------------------------------------
// timestamp_inject_pipe
//
// One-stage registered AXI-stream timestamp injector. On the first beat of a
// packet whose EtherType (bytes 16..17, network order) matches SYNC_ETHERTYPE,
// the lowest-index payload slot whose low 32 bits hold EMPTY_MARKER (and whose
// bytes are all kept) is overwritten with {i_nb_sync, i_curr_tick}. Every
// other beat and bit passes through unchanged, one cycle later.
//
// Ports
//   axis_aclk, axil_areset      clock, asynchronous active-high reset
//   s_axis_*                    input stream (tvalid/tdata/tkeep/tlast/tuser, tready out)
//   m_axis_*                    output stream (tready in)
//   i_enable                    injection enable, sampled on first-beat acceptance
//   i_nb_sync, i_curr_tick      values written into the winning slot
//   o_sync_detected             pulse, sync first beat accepted the cycle before
//   o_slots_full                pulse, that sync first beat had no free slot
//   o_inject_count              successful injections (wraps)
//   o_full_count                sync frames without a free slot (saturates)
//
// Build option
//   TIMESTAMP_INJECT_STATS_EN   when defined, the two statistics counters are
//                               built; otherwise they read as zero.
// ---------------------------------------------------------------------------
// state    | meaning
// ST_SOF   | next accepted beat is the first beat of a packet
// ST_BODY  | inside a multi-beat packet; beats pass unmodified
// ---------------------------------------------------------------------------
module timestamp_inject_pipe #(
    parameter int          DATA_WIDTH           = 512,
    parameter int          TUSER_WIDTH          = 16,
    parameter int          PAYLOAD_OFFSET_BYTES = 18,
    parameter int          SLOT_BITS            = 96,
    parameter logic [15:0] SYNC_ETHERTYPE       = 16'h88B5,
    parameter logic [31:0] EMPTY_MARKER         = 32'hDEADBEEF
) (
    input  logic                     axis_aclk,
    input  logic                     axil_areset,

    input  logic                     s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
    output logic                     s_axis_tready,

    output logic                     m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    input  logic                     m_axis_tready,

    input  logic                     i_enable,
    input  logic [31:0]              i_nb_sync,
    input  logic [63:0]              i_curr_tick,

    output logic                     o_sync_detected,
    output logic                     o_slots_full,
    output logic [31:0]              o_inject_count,
    output logic [15:0]              o_full_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = PAYLOAD_OFFSET_BYTES * 8;
    localparam int SLOT_BYTES = SLOT_BITS / 8;
    localparam int NUM_SLOTS  = (DATA_WIDTH - OFF_BITS) / SLOT_BITS;
    localparam int ET_LSB     = 16 * 8;

    typedef enum logic [0:0] {
        ST_SOF  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t                  state_q, state_d;

    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q,  m_tdata_d;
    logic [KEEP_WIDTH-1:0]   m_tkeep_q,  m_tkeep_d;
    logic                    m_tlast_q,  m_tlast_d;
    logic [TUSER_WIDTH-1:0]  m_tuser_q,  m_tuser_d;
    logic                    sync_pulse_q, sync_pulse_d;
    logic                    full_pulse_q, full_pulse_d;

    logic                    accept;
    logic                    first_beat;
    logic                    is_sync;
    logic [NUM_SLOTS-1:0]    slot_free;
    logic                    slot_hit;
    logic [DATA_WIDTH-1:0]   tdata_inj;

    // The output register can take a new beat when it is empty or draining.
    assign s_axis_tready = !m_tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign first_beat    = (state_q == ST_SOF);

    // Byte 16 carries the EtherType MSB; both bytes must be present.
    assign is_sync = i_enable
                  && (s_axis_tdata[ET_LSB +: 8]     == SYNC_ETHERTYPE[15:8])
                  && (s_axis_tdata[ET_LSB + 8 +: 8] == SYNC_ETHERTYPE[7:0])
                  && (s_axis_tkeep[17:16] == 2'b11);

    // A slot is only usable if its marker reads empty and every byte of it
    // is kept; a truncated slot would lose part of the timestamp.
    always_comb begin
        slot_free = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_free[k] = (s_axis_tdata[OFF_BITS + k*SLOT_BITS +: 32] == EMPTY_MARKER)
                        && (&s_axis_tkeep[PAYLOAD_OFFSET_BYTES + k*SLOT_BYTES +: SLOT_BYTES]);
        end
    end

    // Lowest-index free slot wins; later free slots are left untouched.
    always_comb begin
        tdata_inj = s_axis_tdata;
        slot_hit  = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_free[k] && !slot_hit) begin
                tdata_inj[OFF_BITS + k*SLOT_BITS +: SLOT_BITS] = SLOT_BITS'({i_nb_sync, i_curr_tick});
                slot_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        sync_pulse_d = 1'b0;
        full_pulse_d = 1'b0;

        if (accept) begin
            m_tvalid_d   = 1'b1;
            m_tdata_d    = (first_beat && is_sync && slot_hit) ? tdata_inj : s_axis_tdata;
            m_tkeep_d    = s_axis_tkeep;
            m_tlast_d    = s_axis_tlast;
            m_tuser_d    = s_axis_tuser;
            sync_pulse_d = first_beat && is_sync;
            full_pulse_d = first_beat && is_sync && !slot_hit;

            case (state_q)
                ST_SOF:  if (!s_axis_tlast) state_d = ST_BODY;
                ST_BODY: if (s_axis_tlast)  state_d = ST_SOF;
                default: state_d = ST_SOF;
            endcase
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or posedge axil_areset) begin
        if (axil_areset) begin
            state_q      <= ST_SOF;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= '0;
            sync_pulse_q <= 1'b0;
            full_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            sync_pulse_q <= sync_pulse_d;
            full_pulse_q <= full_pulse_d;
        end
    end

    assign m_axis_tvalid   = m_tvalid_q;
    assign m_axis_tdata    = m_tdata_q;
    assign m_axis_tkeep    = m_tkeep_q;
    assign m_axis_tlast    = m_tlast_q;
    assign m_axis_tuser    = m_tuser_q;
    assign o_sync_detected = sync_pulse_q;
    assign o_slots_full    = full_pulse_q;

`ifdef TIMESTAMP_INJECT_STATS_EN
    logic [31:0] inject_cnt_q;
    logic [15:0] full_cnt_q;

    // Counters move on the same edge as the pulses are registered.
    always_ff @(posedge axis_aclk or posedge axil_areset) begin
        if (axil_areset) begin
            inject_cnt_q <= '0;
            full_cnt_q   <= '0;
        end else begin
            if (sync_pulse_d && !full_pulse_d) begin
                inject_cnt_q <= inject_cnt_q + 32'd1;
            end
            if (full_pulse_d && (full_cnt_q != 16'hFFFF)) begin
                full_cnt_q <= full_cnt_q + 16'd1;
            end
        end
    end

    assign o_inject_count = inject_cnt_q;
    assign o_full_count   = full_cnt_q;
`else
    assign o_inject_count = '0;
    assign o_full_count   = '0;
`endif

endmodule

// File: tb/tb_timestamp_inject_pipe.sv
module tb_timestamp_inject_pipe;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 16;

    logic           axis_aclk;
    logic           axil_areset;
    logic           s_axis_tvalid;
    logic [DW-1:0]  s_axis_tdata;
    logic [KW-1:0]  s_axis_tkeep;
    logic           s_axis_tlast;
    logic [UW-1:0]  s_axis_tuser;
    logic           s_axis_tready;
    logic           m_axis_tvalid;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;
    logic [UW-1:0]  m_axis_tuser;
    logic           m_axis_tready;
    logic           i_enable;
    logic [31:0]    i_nb_sync;
    logic [63:0]    i_curr_tick;
    logic           o_sync_detected;
    logic           o_slots_full;
    logic [31:0]    o_inject_count;
    logic [15:0]    o_full_count;

    timestamp_inject_pipe dut (
        .axis_aclk       (axis_aclk),
        .axil_areset     (axil_areset),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tready   (m_axis_tready),
        .i_enable        (i_enable),
        .i_nb_sync       (i_nb_sync),
        .i_curr_tick     (i_curr_tick),
        .o_sync_detected (o_sync_detected),
        .o_slots_full    (o_slots_full),
        .o_inject_count  (o_inject_count),
        .o_full_count    (o_full_count)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    beat_t         sb_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            n_out = 0;
    int            n_sync_seen = 0;
    int            n_full_seen = 0;
    logic [DW-1:0] last_out_data = '0;
    logic          rdy_random = 1'b0;
    logic          rdy_hold = 1'b1;

    // model state
    logic          mdl_sof = 1'b1;
    logic          pend_sync = 1'b0;
    logic          pend_full = 1'b0;
    logic [31:0]   mdl_inj_cnt = '0;
    logic [15:0]   mdl_full_cnt = '0;

    always @(posedge axis_aclk) cyc <= cyc + 1;

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            m_axis_tready = rdy_random ? (($urandom & 1) != 0) : rdy_hold;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Scoreboard / monitor: runs at negedge, where handshakes and inputs are stable.
    initial begin : monitor
        logic          stall_prev;
        logic [DW-1:0] p_data;
        logic [KW-1:0] p_keep;
        logic          p_last;
        logic [UW-1:0] p_user;
        stall_prev = 1'b0;
        p_data = '0; p_keep = '0; p_last = 1'b0; p_user = '0;
        forever begin
            @(negedge axis_aclk);
            if (axil_areset) begin
                sb_q.delete();
                mdl_sof = 1'b1;
                pend_sync = 1'b0;
                pend_full = 1'b0;
                mdl_inj_cnt = '0;
                mdl_full_cnt = '0;
                stall_prev = 1'b0;
            end else begin
`ifdef TIMESTAMP_INJECT_STATS_EN
                if (pend_sync && !pend_full) mdl_inj_cnt = mdl_inj_cnt + 32'd1;
                if (pend_full && mdl_full_cnt != 16'hFFFF) mdl_full_cnt = mdl_full_cnt + 16'd1;
`endif
                n_cmp++;
                if (o_sync_detected !== pend_sync || o_slots_full !== pend_full) begin
                    n_bad++;
                    $display("FAIL pulses @%0t: sync/full got %b/%b want %b/%b", $time,
                             o_sync_detected, o_slots_full, pend_sync, pend_full);
                end
                n_cmp++;
                if (o_inject_count !== mdl_inj_cnt || o_full_count !== mdl_full_cnt) begin
                    n_bad++;
                    $display("FAIL counters @%0t: inject/full got %0d/%0d want %0d/%0d", $time,
                             o_inject_count, o_full_count, mdl_inj_cnt, mdl_full_cnt);
                end
                if (o_sync_detected === 1'b1) n_sync_seen++;
                if (o_slots_full === 1'b1) n_full_seen++;

                if (stall_prev) begin
                    n_cmp++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_data || m_axis_tkeep !== p_keep
                        || m_axis_tlast !== p_last || m_axis_tuser !== p_user) begin
                        n_bad++;
                        $display("FAIL stall_hold @%0t: outputs changed while stalled (valid %b)",
                                 $time, m_axis_tvalid);
                    end
                end

                if (m_axis_tvalid && m_axis_tready) begin
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL extra_beat @%0t: output beat with empty scoreboard", $time);
                    end else begin
                        beat_t e;
                        e = sb_q.pop_front();
                        if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep
                            || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
                            n_bad++;
                            $display("FAIL beat @%0t: got data %h keep %h last %b user %h want data %h keep %h last %b user %h",
                                     $time, m_axis_tdata[335:128], m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                                     e.data[335:128], e.keep, e.last, e.user);
                        end
                    end
                    last_out_data = m_axis_tdata;
                    n_out++;
                end

                stall_prev = m_axis_tvalid && !m_axis_tready;
                p_data = m_axis_tdata; p_keep = m_axis_tkeep;
                p_last = m_axis_tlast; p_user = m_axis_tuser;

                pend_sync = 1'b0;
                pend_full = 1'b0;
                if (s_axis_tvalid && s_axis_tready) begin
                    beat_t b;
                    logic  hit;
                    logic [15:0] et;
                    b.data = s_axis_tdata;
                    b.keep = s_axis_tkeep;
                    b.last = s_axis_tlast;
                    b.user = s_axis_tuser;
                    et = {s_axis_tdata[135:128], s_axis_tdata[143:136]};
                    if (mdl_sof && i_enable && et == 16'h88B5 && s_axis_tkeep[16] && s_axis_tkeep[17]) begin
                        pend_sync = 1'b1;
                        hit = 1'b0;
                        for (int k = 0; k < 3; k++) begin
                            if (!hit && s_axis_tdata[144 + 96*k +: 32] == 32'hDEADBEEF
                                && (&s_axis_tkeep[18 + 12*k +: 12])) begin
                                b.data[144 + 96*k +: 96] = {i_nb_sync, i_curr_tick};
                                hit = 1'b1;
                            end
                        end
                        pend_full = !hit;
                    end
                    mdl_sof = s_axis_tlast;
                    sb_q.push_back(b);
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk_frame(input logic [15:0] et, input logic [31:0] m0,
                                                input logic [31:0] m1, input logic [31:0] m2);
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
        d[128 +: 8] = et[15:8];
        d[136 +: 8] = et[7:0];
        d[144 +: 32] = m0;
        d[240 +: 32] = m1;
        d[336 +: 32] = m2;
        return d;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [UW-1:0] u, input logic [31:0] nb, input logic [63:0] tk);
        int   w;
        logic done;
        w = 0;
        done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        i_nb_sync     = nb;
        i_curr_tick   = tk;
        while (!done) begin
            @(negedge axis_aclk);
            if (s_axis_tready) begin
                done = 1'b1;
            end else begin
                w++;
                if (w > 2000) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles", w);
                    break;
                end
            end
        end
        @(posedge axis_aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        rdy_random = 1'b0;
        rdy_hold = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            if (sb_q.size() == 0 && !m_axis_tvalid) break;
            w++;
            if (w > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: %0d beats still pending, valid %b", sb_q.size(), m_axis_tvalid);
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        axil_areset = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #1;
        axil_areset = 1'b0;
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic test_reset();
        axil_areset = 1'b1;
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0
            || m_axis_tlast !== 1'b0 || m_axis_tuser !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid %b last %b keep %h user %h, want all zero",
                     m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser);
        end
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tready: got %b want 1", s_axis_tready);
        end
        n_cmp++;
        if (o_sync_detected !== 1'b0 || o_slots_full !== 1'b0 || o_inject_count !== '0 || o_full_count !== '0) begin
            n_bad++;
            $display("FAIL reset_stats: sync %b full %b inj %0d fullcnt %0d want 0", o_sync_detected,
                     o_slots_full, o_inject_count, o_full_count);
        end
        @(posedge axis_aclk);
        #1;
        axil_areset = 1'b0;
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic test_single_sync();
        logic [DW-1:0] d;
        int s0;
        s0 = n_sync_seen;
        i_enable = 1'b1;
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        send_beat(d, '1, 1'b1, 16'hA5A5, 32'h5, 64'h1234);
        wait_drain();
        n_cmp++;
        if (last_out_data[144 +: 96] !== {32'h5, 64'h1234}) begin
            n_bad++;
            $display("FAIL single_slot0: got %h want %h", last_out_data[144 +: 96], {32'h5, 64'h1234});
        end
        n_cmp++;
        if (last_out_data[240 +: 32] !== 32'hDEADBEEF || last_out_data[143:0] !== d[143:0]) begin
            n_bad++;
            $display("FAIL single_rest: slot1 marker %h want deadbeef", last_out_data[240 +: 32]);
        end
        n_cmp++;
        if (n_sync_seen !== s0 + 1) begin
            n_bad++;
            $display("FAIL single_pulse: sync pulses got %0d want %0d", n_sync_seen - s0, 1);
        end
`ifdef TIMESTAMP_INJECT_STATS_EN
        n_cmp++;
        if (o_inject_count !== 32'd1) begin
            n_bad++;
            $display("FAIL single_count: inject_count got %0d want 1", o_inject_count);
        end
`endif
    endtask

    task automatic test_slot1();
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        d = mk_frame(16'h88B5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        send_beat(d, '1, 1'b1, 16'h0001, 32'h77, 64'hCAFE_0000_0000_0042);
        wait_drain();
        n_cmp++;
        if (last_out_data[144 +: 96] !== d[144 +: 96]
            || last_out_data[240 +: 96] !== {32'h77, 64'hCAFE_0000_0000_0042}) begin
            n_bad++;
            $display("FAIL slot1: slot0 %h (want %h) slot1 %h", last_out_data[144 +: 96], d[144 +: 96],
                     last_out_data[240 +: 96]);
        end
        // slot 0 free by marker but one of its bytes not kept: slot 1 must win
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        k = '1;
        k[25] = 1'b0;
        send_beat(d, k, 1'b1, 16'h0002, 32'h78, 64'h99);
        wait_drain();
        n_cmp++;
        if (last_out_data[144 +: 96] !== d[144 +: 96] || last_out_data[240 +: 96] !== {32'h78, 64'h99}) begin
            n_bad++;
            $display("FAIL keep_partial: slot0 %h slot1 %h want slot1 %h", last_out_data[144 +: 96],
                     last_out_data[240 +: 96], {32'h78, 64'h99});
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] d;
        int f0;
        logic [31:0] inj0;
        f0 = n_full_seen;
        inj0 = o_inject_count;
        d = mk_frame(16'h88B5, 32'h1, 32'h2, 32'h3);
        send_beat(d, '1, 1'b1, 16'h0003, 32'h9, 64'h9);
        wait_drain();
        n_cmp++;
        if (last_out_data !== d) begin
            n_bad++;
            $display("FAIL full_data: got %h want %h", last_out_data[335:128], d[335:128]);
        end
        n_cmp++;
        if (n_full_seen !== f0 + 1 || o_inject_count !== inj0) begin
            n_bad++;
            $display("FAIL full_pulse: full pulses %0d want 1, inject %0d want %0d", n_full_seen - f0,
                     o_inject_count, inj0);
        end
    endtask

    task automatic test_multibeat();
        logic [DW-1:0] d;
        int s0;
        s0 = n_sync_seen;
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'h0, 32'h0);
        send_beat(d, '1, 1'b0, 16'h0010, 32'h21, 64'h21);
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
        send_beat(d, '1, 1'b0, 16'h0011, 32'h22, 64'h22);
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        send_beat(d, '1, 1'b1, 16'h0012, 32'h23, 64'h23);
        wait_drain();
        n_cmp++;
        if (last_out_data !== d) begin
            n_bad++;
            $display("FAIL multibeat_tail: last beat modified, slot0 %h", last_out_data[144 +: 96]);
        end
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'h0, 32'h0);
        send_beat(d, '1, 1'b1, 16'h0013, 32'h24, 64'h24);
        wait_drain();
        n_cmp++;
        if (n_sync_seen !== s0 + 2 || last_out_data[144 +: 96] !== {32'h24, 64'h24}) begin
            n_bad++;
            $display("FAIL multibeat_next: sync pulses %0d want 2, slot0 %h", n_sync_seen - s0,
                     last_out_data[144 +: 96]);
        end
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] d;
        int s0;
        s0 = n_sync_seen;
        i_enable = 1'b1;
        d = mk_frame(16'h0800, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        send_beat(d, '1, 1'b1, 16'h0020, 32'h31, 64'h31);
        wait_drain();
        n_cmp++;
        if (last_out_data !== d) begin
            n_bad++;
            $display("FAIL pass_ethertype: slot0 got %h want %h", last_out_data[144 +: 96], d[144 +: 96]);
        end
        i_enable = 1'b0;
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        send_beat(d, '1, 1'b1, 16'h0021, 32'h32, 64'h32);
        wait_drain();
        i_enable = 1'b1;
        n_cmp++;
        if (last_out_data !== d || n_sync_seen !== s0) begin
            n_bad++;
            $display("FAIL pass_disabled: slot0 %h want %h, sync pulses %0d want 0",
                     last_out_data[144 +: 96], d[144 +: 96], n_sync_seen - s0);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int o0;
        o0 = n_out;
        i_enable = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            send_beat(mk_frame(16'h88B5, 32'hDEADBEEF, 32'h0, 32'h0), '1, 1'b1, 16'(i), 32'(i), 64'(i));
        end
        n_cmp++;
        if (cyc - t0 !== 20) begin
            n_bad++;
            $display("FAIL throughput: 20 beats took %0d cycles want 20", cyc - t0);
        end
        wait_drain();
        n_cmp++;
        if (n_out - o0 !== 20) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d beats want 20", n_out - o0);
        end
    endtask

    task automatic test_random_stall();
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [15:0]   et;
        logic [31:0]   m0, m1, m2;
        int o0;
        int bi;
        o0 = n_out;
        rdy_random = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            et = ($urandom_range(0, 3) != 0) ? 16'h88B5 : 16'h0800;
            m0 = (($urandom & 1) != 0) ? 32'hDEADBEEF : $urandom;
            m1 = (($urandom & 1) != 0) ? 32'hDEADBEEF : $urandom;
            m2 = (($urandom & 1) != 0) ? 32'hDEADBEEF : $urandom;
            d = mk_frame(et, m0, m1, m2);
            k = '1;
            if ($urandom_range(0, 7) == 0) begin
                bi = int'($urandom_range(16, 63));
                k[bi] = 1'b0;
            end
            i_enable = ($urandom_range(0, 7) != 0);
            send_beat(d, k, ($urandom_range(0, 2) == 0), 16'($urandom), $urandom, {$urandom, $urandom});
        end
        wait_drain();
        i_enable = 1'b1;
        n_cmp++;
        if (n_out - o0 !== 1000) begin
            n_bad++;
            $display("FAIL random_count: got %0d beats want 1000", n_out - o0);
        end
    endtask

    task automatic test_reset_midpacket();
        logic [DW-1:0] d;
        int s0;
        i_enable = 1'b1;
        d = mk_frame(16'h0800, 32'h0, 32'h0, 32'h0);
        send_beat(d, '1, 1'b0, 16'h0030, 32'h41, 64'h41);
        wait_drain();
        pulse_reset();
        s0 = n_sync_seen;
        d = mk_frame(16'h88B5, 32'hDEADBEEF, 32'h0, 32'h0);
        send_beat(d, '1, 1'b1, 16'h0031, 32'h42, 64'h4242);
        wait_drain();
        n_cmp++;
        if (last_out_data[144 +: 96] !== {32'h42, 64'h4242} || n_sync_seen !== s0 + 1) begin
            n_bad++;
            $display("FAIL reset_midpacket: slot0 %h want %h, sync pulses %0d want 1",
                     last_out_data[144 +: 96], {32'h42, 64'h4242}, n_sync_seen - s0);
        end
    endtask

    initial begin
        axil_areset   = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        i_enable      = 1'b0;
        i_nb_sync     = '0;
        i_curr_tick   = '0;
        test_reset();
        test_single_sync();
        test_slot1();
        test_full();
        test_multibeat();
        test_passthrough();
        test_back_to_back();
        test_random_stall();
        test_reset_midpacket();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
